// File: rtl/ysyx_23060201_idu_stage_pkg.sv
// Shared constants, encodings and helpers for the IF/ID stage and its decoder.
package ysyx_23060201_idu_stage_pkg;

  localparam logic [31:0] MBASE       = 32'h8000_0000;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_OPIMM   = 4'd7,
    OP_OP      = 4'd8,
    OP_SYSTEM  = 4'd9,
    OP_ILLEGAL = 4'd10
  } op_type_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  // Buffer occupancy: EMPTY, ONE (head only), TWO (head + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  // SYSTEM words accepted: exactly ecall/ebreak when funct3 == 0, any CSR op otherwise.
  function automatic logic system_legal(input logic [31:0] inst);
    logic ok;
    case (inst[14:12])
      3'b000:  ok = (inst == ECALL_INST) || (inst == EBREAK_INST);
      3'b100:  ok = 1'b0;
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_23060201_idu_stage_if.sv
// Handshake bundle between IFU -> IDU -> EXU. The IDU uses the slave view.
interface ysyx_23060201_idu_stage_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import ysyx_23060201_idu_stage_pkg::*;

  // IFU side
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [DW-1:0] in_inst;

  // EXU side
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_inst;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic [31:0]   imm;
  op_type_e      op_type;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic          rf_wen;
  logic          is_ebreak;
  logic          illegal;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, rs1, rs2, rd, imm,
           op_type, funct3, funct7b5, rf_wen, is_ebreak, illegal
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, rs1, rs2, rd, imm,
           op_type, funct3, funct7b5, rf_wen, is_ebreak, illegal
  );

endinterface

// File: rtl/ysyx_23060201_imm_gen.sv
// RV32I immediate generator: selects and sign-extends the immediate for a format.
module ysyx_23060201_imm_gen
  import ysyx_23060201_idu_stage_pkg::*;
(
  input  logic [31:7] i_inst,
  input  imm_fmt_e    i_fmt,
  output logic [31:0] o_imm
);

  // Immediate assembly per encoding format; formats without an immediate give zero.
  always_comb begin
    o_imm = 32'h0000_0000;
    case (i_fmt)
      FMT_I:   o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S:   o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B:   o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                        i_inst[11:8], 1'b0};
      FMT_U:   o_imm = {i_inst[31:12], 12'h000};
      FMT_J:   o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                        i_inst[30:21], 1'b0};
      default: o_imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_idu_stage.sv
// IF/ID boundary: 2-entry skid buffer with flush, plus combinational RV32I decode
// of the head entry.
module ysyx_23060201_idu_stage
  import ysyx_23060201_idu_stage_pkg::*;
#(
  parameter int                        MEM_ADDR_WIDTH = 32,
  parameter int                        DATA_WIDTH     = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC       = MBASE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  ysyx_23060201_idu_stage_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INST);

  occ_e                      r_state;
  logic                      r_out_valid;
  logic                      r_in_ready;
  logic [MEM_ADDR_WIDTH-1:0] r_head_pc;
  logic [DATA_WIDTH-1:0]     r_head_inst;
  logic [MEM_ADDR_WIDTH-1:0] r_skid_pc;
  logic [DATA_WIDTH-1:0]     r_skid_inst;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // Occupancy FSM and entry storage; handshake outputs are registered from the next state.
  // An emptied buffer reloads the head with {RESET_PC, nop} so decode idles on a nop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_head_pc   <= RESET_PC;
      r_head_inst <= NOP_W;
      r_skid_pc   <= RESET_PC;
      r_skid_inst <= NOP_W;
    end else if (flush) begin
      // Redirect wins over everything: concurrent input is dropped.
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_head_pc   <= RESET_PC;
      r_head_inst <= NOP_W;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
            r_head_pc   <= bus.in_pc;
            r_head_inst <= bus.in_inst;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_head_pc   <= bus.in_pc;
            r_head_inst <= bus.in_inst;
          end else if (w_in_fire) begin
            r_state     <= ST_TWO;
            r_in_ready  <= 1'b0;
            r_skid_pc   <= bus.in_pc;
            r_skid_inst <= bus.in_inst;
          end else if (w_out_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_head_pc   <= RESET_PC;
            r_head_inst <= NOP_W;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the consume side can move.
          if (w_out_fire) begin
            r_state     <= ST_ONE;
            r_in_ready  <= 1'b1;
            r_head_pc   <= r_skid_pc;
            r_head_inst <= r_skid_inst;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_head_pc   <= RESET_PC;
          r_head_inst <= NOP_W;
        end
      endcase
    end
  end

  // ---------------- decode of the head entry ----------------
  logic [31:0] w_inst;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  op_type_e    w_op_type;
  imm_fmt_e    w_fmt;
  logic        w_writes_rd;
  logic [31:0] w_imm;

  assign w_inst   = r_head_inst[31:0];
  assign w_opcode = w_inst[6:0];
  assign w_rd     = w_inst[11:7];

  // Opcode classification: class, immediate format and whether the class writes rd.
  always_comb begin
    w_op_type   = OP_ILLEGAL;
    w_fmt       = FMT_NONE;
    w_writes_rd = 1'b0;
    case (w_opcode)
      OPC_LUI:    begin w_op_type = OP_LUI;    w_fmt = FMT_U; w_writes_rd = 1'b1; end
      OPC_AUIPC:  begin w_op_type = OP_AUIPC;  w_fmt = FMT_U; w_writes_rd = 1'b1; end
      OPC_JAL:    begin w_op_type = OP_JAL;    w_fmt = FMT_J; w_writes_rd = 1'b1; end
      OPC_JALR:   begin w_op_type = OP_JALR;   w_fmt = FMT_I; w_writes_rd = 1'b1; end
      OPC_BRANCH: begin w_op_type = OP_BRANCH; w_fmt = FMT_B; w_writes_rd = 1'b0; end
      OPC_LOAD:   begin w_op_type = OP_LOAD;   w_fmt = FMT_I; w_writes_rd = 1'b1; end
      OPC_STORE:  begin w_op_type = OP_STORE;  w_fmt = FMT_S; w_writes_rd = 1'b0; end
      OPC_OPIMM:  begin w_op_type = OP_OPIMM;  w_fmt = FMT_I; w_writes_rd = 1'b1; end
      OPC_OP:     begin w_op_type = OP_OP;     w_fmt = FMT_NONE; w_writes_rd = 1'b1; end
      OPC_SYSTEM: begin
        if (system_legal(w_inst)) begin
          // CSR ops return the old CSR value in rd; ecall/ebreak write nothing.
          w_op_type   = OP_SYSTEM;
          w_writes_rd = (w_inst[14:12] != 3'b000);
        end else begin
          w_op_type   = OP_ILLEGAL;
          w_writes_rd = 1'b0;
        end
        w_fmt = FMT_NONE;
      end
      default: begin
        w_op_type   = OP_ILLEGAL;
        w_fmt       = FMT_NONE;
        w_writes_rd = 1'b0;
      end
    endcase
  end

  ysyx_23060201_imm_gen u_imm_gen (
    .i_inst (w_inst[31:7]),
    .i_fmt  (w_fmt),
    .o_imm  (w_imm)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pc    = r_head_pc;
  assign bus.out_inst  = r_head_inst;
  assign bus.rs1       = w_inst[19:15];
  assign bus.rs2       = w_inst[24:20];
  assign bus.rd        = w_rd;
  assign bus.imm       = w_imm;
  assign bus.op_type   = w_op_type;
  assign bus.funct3    = w_inst[14:12];
  assign bus.funct7b5  = w_inst[30];
  assign bus.rf_wen    = w_writes_rd && (w_rd != 5'd0);
  assign bus.is_ebreak = (w_inst == EBREAK_INST);
  assign bus.illegal   = (w_op_type == OP_ILLEGAL);

endmodule

// File: tb/tb_ysyx_23060201_idu_stage.sv
// Scoreboard bench for the IF/ID stage: the driver queues expected bundles on
// accept, a negedge monitor pops and compares on every output fire.
module tb_ysyx_23060201_idu_stage;
  import ysyx_23060201_idu_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] imm;
    op_type_e    op;
    logic        wen;
    logic        eb;
    logic        il;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  int   tests;
  int   fails;
  int   nbund;
  exp_t tbl [12];
  exp_t exp_q [$];

  ysyx_23060201_idu_stage_if bus ();

  ysyx_23060201_idu_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] inst, input logic [4:0] rd,
                              input logic [31:0] imm, input op_type_e op,
                              input logic wen, input logic eb, input logic il);
    exp_t e;
    e.pc = 32'h0; e.inst = inst; e.rd = rd; e.imm = imm; e.op = op;
    e.wen = wen; e.eb = eb; e.il = il;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Present table entry idx at pc; queue its expectation only if it is accepted outside a flush.
  task automatic push(input int idx, input logic [31:0] pc, output int waits);
    exp_t e;
    logic fire;
    logic fl;
    logic done;
    e = tbl[idx];
    e.pc = pc;
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = e.inst;
    waits = 0;
    done  = 1'b0;
    while (!done && waits < 40) begin
      @(negedge clk);
      fire = bus.in_ready;
      fl   = flush;
      @(posedge clk);
      #1;
      waits++;
      if (fire) begin
        done = 1'b1;
        if (!fl) exp_q.push_back(e);
      end
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: word %0d not accepted after %0d cycles", idx, waits);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every output fire must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      exp_t e;
      exp_t a;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_bundle: got pc=%h inst=%h, required no output", bus.out_pc, bus.out_inst);
      end else begin
        e = exp_q.pop_front();
        a.pc = bus.out_pc; a.inst = bus.out_inst; a.rd = bus.rd; a.imm = bus.imm;
        a.op = bus.op_type; a.wen = bus.rf_wen; a.eb = bus.is_ebreak; a.il = bus.illegal;
        if (a !== e || bus.rs1 !== e.inst[19:15] || bus.rs2 !== e.inst[24:20] ||
            bus.funct3 !== e.inst[14:12] || bus.funct7b5 !== e.inst[30]) begin
          fails++;
          $display("FAIL bundle%0d: got pc=%h inst=%h rd=%0d imm=%h op=%0d wen=%b eb=%b il=%b rs1=%0d rs2=%0d f3=%0d f7b5=%b, required pc=%h inst=%h rd=%0d imm=%h op=%0d wen=%b eb=%b il=%b",
                   nbund, a.pc, a.inst, a.rd, a.imm, a.op, a.wen, a.eb, a.il, bus.rs1, bus.rs2, bus.funct3, bus.funct7b5,
                   e.pc, e.inst, e.rd, e.imm, e.op, e.wen, e.eb, e.il);
        end
      end
      nbund++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int seq [9] = '{0, 1, 2, 3, 7, 8, 9, 10, 11};
    tests = 0; fails = 0; nbund = 0;
    clk = 1'b0; rst = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = 32'h0; bus.in_inst = 32'h0; bus.out_ready = 1'b0;

    tbl[0]  = mk(32'h0050_0093,  5'd1, 32'h0000_0005, OP_OPIMM,   1'b1, 1'b0, 1'b0); // addi x1,x0,5
    tbl[1]  = mk(32'h0020_81b3,  5'd3, 32'h0000_0000, OP_OP,      1'b1, 1'b0, 1'b0); // add x3,x1,x2
    tbl[2]  = mk(32'h1234_52b7,  5'd5, 32'h1234_5000, OP_LUI,     1'b1, 1'b0, 1'b0); // lui x5,0x12345
    tbl[3]  = mk(32'h0020_a423,  5'd8, 32'h0000_0008, OP_STORE,   1'b0, 1'b0, 1'b0); // sw x2,8(x1)
    tbl[4]  = mk(32'hfe00_0ee3, 5'd29, 32'hffff_fffc, OP_BRANCH,  1'b0, 1'b0, 1'b0); // beq x0,x0,-4
    tbl[5]  = mk(32'h0080_006f,  5'd0, 32'h0000_0008, OP_JAL,     1'b0, 1'b0, 1'b0); // jal x0,8
    tbl[6]  = mk(32'h0010_0073,  5'd0, 32'h0000_0000, OP_SYSTEM,  1'b0, 1'b1, 1'b0); // ebreak
    tbl[7]  = mk(32'hffff_ffff, 5'd31, 32'h0000_0000, OP_ILLEGAL, 1'b0, 1'b0, 1'b1); // illegal
    tbl[8]  = mk(32'hffc1_2503, 5'd10, 32'hffff_fffc, OP_LOAD,    1'b1, 1'b0, 1'b0); // lw x10,-4(x2)
    tbl[9]  = mk(32'h0000_1397,  5'd7, 32'h0000_1000, OP_AUIPC,   1'b1, 1'b0, 1'b0); // auipc x7,1
    tbl[10] = mk(32'h0002_80e7,  5'd1, 32'h0000_0000, OP_JALR,    1'b1, 1'b0, 1'b0); // jalr x1,0(x5)
    tbl[11] = mk(32'h0000_0013,  5'd0, 32'h0000_0000, OP_OPIMM,   1'b0, 1'b0, 1'b0); // nop

    // 1. reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_pc",    bus.out_pc,         32'h8000_0000);
    chk("rst_out_inst",  bus.out_inst,       32'h0000_0013);

    // 2. streaming with out_ready held high: one accept per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push(seq[i], 32'h8000_0000 + 32'(4 * i), w);
      chk("stream_accept_cycles", 32'(w), 32'd1);
      if (i == 0) chk("stream_latency_valid", 32'(bus.out_valid), 32'd1);
    end
    drain("stream_drain");

    // 3. back-pressure: third word held until out_ready returns, order preserved
    bus.out_ready = 1'b0;
    push(4, 32'h8000_0100, w);
    chk("bp_ready_after_1", 32'(bus.in_ready), 32'd1);
    push(5, 32'h8000_0104, w);
    chk("bp_ready_after_2", 32'(bus.in_ready), 32'd0);
    fork
      push(6, 32'h8000_0108, w);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_held", 32'(bus.in_ready), 32'd0);
        chk("bp_head_pc",    bus.out_pc,        32'h8000_0100);
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // 4a. flush with two entries buffered and a word presented on the same edge
    bus.out_ready = 1'b0;
    push(2, 32'h8000_0200, w);
    push(3, 32'h8000_0204, w);
    bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0208; bus.in_inst = tbl[9].inst;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    exp_q.delete();
    chk("flush2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush2_in_ready",  32'(bus.in_ready),  32'd1);
    chk("flush2_out_pc",    bus.out_pc,         32'h8000_0000);
    chk("flush2_out_inst",  bus.out_inst,       32'h0000_0013);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 4b. flush with one entry, concurrent accepted input and concurrent consume
    bus.out_ready = 1'b0;
    push(10, 32'h8000_0300, w);
    bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0304; bus.in_inst = tbl[11].inst;
    bus.out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush1_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("flush1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush1_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (4) @(posedge clk);
    #1;

    // 6. asynchronous reset with two entries buffered
    bus.out_ready = 1'b0;
    push(0, 32'h8000_0400, w);
    push(1, 32'h8000_0404, w);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_out_pc",    bus.out_pc,         32'h8000_0000);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push(8, 32'h8000_0500, w);
    drain("arst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
